// File: rtl/gray_counter_ctrl.sv
// gray_counter_ctrl: sequencing controller for the LED Gray counter.
// Turns button levels into a paced count-enable, a clear pulse and a direction bit.
//
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   start         - rising edge starts (IDLE/DONE) or resumes (PAUSE)
//   stop          - rising edge pauses (RUN) or aborts (PAUSE/DONE)
//   step          - rising edge issues one step while paused
//   dir_in        - requested direction, latched on entry to RUN
//   single        - 1: stop after 2^N steps, 0: run continuously
//   cnt_en        - one-cycle count enable to the Gray counter
//   cnt_clr       - one-cycle clear to the Gray counter
//   cnt_up        - direction presented to the counter
//   busy, done    - status flags (RUN/PAUSE, DONE)
//   state         - IDLE=0, RUN=1, PAUSE=2, DONE=3
//   step_cnt      - steps issued since the last clear
module gray_counter_ctrl #(
    parameter int N        = 4,
    parameter int distance = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       step,
    input  logic       dir_in,
    input  logic       single,
    output logic       cnt_en,
    output logic       cnt_clr,
    output logic       cnt_up,
    output logic       busy,
    output logic       done,
    output logic [1:0] state,
    output logic [N:0] step_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int            PW   = $clog2(distance);
    localparam logic [PW-1:0] LAST = PW'(distance - 1);
    localparam logic [N:0]    FULL = {1'b1, {N{1'b0}}};

    state_t        fsm;
    logic          start_q;
    logic          stop_q;
    logic          step_q;
    logic [PW-1:0] presc;

    logic          start_e;
    logic          stop_e;
    logic          step_e;
    logic          start_hit;
    logic          stop_hit;
    logic          step_hit;
    logic [PW-1:0] presc_nx;
    logic [N:0]    step_inc;
    logic [N:0]    step_nx;
    logic          finish;

    // Edge detect; stop beats start beats step.
    assign start_e   = start & ~start_q;
    assign stop_e    = stop & ~stop_q;
    assign step_e    = step & ~step_q;
    assign stop_hit  = stop_e;
    assign start_hit = start_e & ~stop_e;
    assign step_hit  = step_e & ~stop_e & ~start_e;

    // presc holds the number of RUN cycles completed in the current
    // period; the pulse cycle is the one in which it reads LAST.
    assign presc_nx = (presc == LAST) ? '0 : presc + PW'(1);

    // Continuous mode drops bit N so the count wraps 2^N-1 -> 0.
    assign step_inc = step_cnt + (N+1)'(1);
    assign step_nx  = single ? step_inc : {1'b0, step_inc[N-1:0]};
    assign finish   = single && (step_inc == FULL);

    assign state = fsm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm      <= IDLE;
            start_q  <= 1'b1;
            stop_q   <= 1'b1;
            step_q   <= 1'b1;
            presc    <= '0;
            step_cnt <= '0;
            cnt_en   <= 1'b0;
            cnt_clr  <= 1'b0;
            cnt_up   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            start_q <= start;
            stop_q  <= stop;
            step_q  <= step;
            cnt_en  <= 1'b0;
            cnt_clr <= 1'b0;
            case (fsm)
                IDLE, DONE: begin
                    if (start_hit) begin
                        fsm      <= RUN;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        cnt_clr  <= 1'b1;
                        cnt_up   <= dir_in;
                        step_cnt <= '0;
                        presc    <= '0;
                    end else if (stop_hit && fsm == DONE) begin
                        fsm  <= IDLE;
                        done <= 1'b0;
                    end
                end
                RUN: begin
                    // The cycle ending on a stop still counts as elapsed,
                    // so a wrap lost to stop fires on the first resumed cycle.
                    presc <= presc_nx;
                    if (stop_hit) begin
                        fsm <= PAUSE;
                    end else if (presc_nx == LAST) begin
                        cnt_en   <= 1'b1;
                        step_cnt <= step_nx;
                        if (finish) begin
                            fsm  <= DONE;
                            busy <= 1'b0;
                            done <= 1'b1;
                        end
                    end
                end
                PAUSE: begin
                    if (stop_hit) begin
                        fsm  <= IDLE;
                        busy <= 1'b0;
                    end else if (start_hit) begin
                        cnt_up <= dir_in;
                        if (presc == LAST) begin
                            cnt_en   <= 1'b1;
                            step_cnt <= step_nx;
                        end
                        if (presc == LAST && finish) begin
                            fsm  <= DONE;
                            busy <= 1'b0;
                            done <= 1'b1;
                        end else begin
                            fsm <= RUN;
                        end
                    end else if (step_hit) begin
                        cnt_en   <= 1'b1;
                        step_cnt <= step_nx;
                        if (finish) begin
                            fsm  <= DONE;
                            busy <= 1'b0;
                            done <= 1'b1;
                        end
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gray_counter_ctrl.sv
// tb_gray_counter_ctrl: scoreboard bench for gray_counter_ctrl.
// Expected cnt_en pulses are queued as stimulus is driven and popped on each pulse.
module tb_gray_counter_ctrl;

    localparam int N    = 4;
    localparam int DIST = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic       step;
    logic       dir_in;
    logic       single;
    logic       cnt_en;
    logic       cnt_clr;
    logic       cnt_up;
    logic       busy;
    logic       done;
    logic [1:0] state;
    logic [N:0] step_cnt;

    gray_counter_ctrl #(.N(N), .distance(DIST)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .step     (step),
        .dir_in   (dir_in),
        .single   (single),
        .cnt_en   (cnt_en),
        .cnt_clr  (cnt_clr),
        .cnt_up   (cnt_up),
        .busy     (busy),
        .done     (done),
        .state    (state),
        .step_cnt (step_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int cnt;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_err  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input int c, input int n);
        exp_t e;
        e.cyc = c;
        e.cnt = n;
        q.push_back(e);
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Pulse monitor
    always @(negedge clk) begin
        if (cnt_en) begin
            chk("en_clr_overlap", int'(cnt_clr), 0);
            if (q.size() == 0) begin
                chk("en_unexpected", int'(cnt_en), 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("en_cyc", cyc, e.cyc);
                chk("en_cnt", int'(step_cnt), e.cnt);
            end
        end
    end

    int m;
    int s;
    int r;
    int el;

    initial begin
        rst    = 1'b1;
        start  = 1'b1;
        stop   = 1'b0;
        step   = 1'b0;
        dir_in = 1'b1;
        single = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_state", int'(state), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_cnt", int'(step_cnt), 0);
        chk("rst_up", int'(cnt_up), 0);
        chk("rst_clr", int'(cnt_clr), 0);
        start = 1'b0;
        @(negedge clk);

        // Single sweep, up
        start = 1'b1;
        m = cyc;
        for (int j = 1; j <= 16; j++) push(m + DIST * j, j);
        @(negedge clk);
        start = 1'b0;
        chk("start_clr", int'(cnt_clr), 1);
        chk("start_state", int'(state), 1);
        chk("start_busy", int'(busy), 1);
        chk("start_up", int'(cnt_up), 1);
        @(negedge clk);
        chk("clr_once", int'(cnt_clr), 0);
        wait_to(m + 16 * DIST - 1);
        chk("done_early", int'(done), 0);
        wait_to(m + 16 * DIST);
        chk("done_rise", int'(done), 1);
        chk("busy_fall", int'(busy), 0);
        wait_to(m + 16 * DIST + 15);
        chk("sweep_state", int'(state), 3);
        chk("sweep_cnt", int'(step_cnt), 16);
        chk("sweep_up", int'(cnt_up), 1);

        // Pause, step, resume
        dir_in = 1'b0;
        start  = 1'b1;
        m = cyc;
        for (int j = 1; j <= 5; j++) push(m + DIST * j, j);
        @(negedge clk);
        start = 1'b0;
        chk("rs_clr", int'(cnt_clr), 1);
        chk("rs_up", int'(cnt_up), 0);
        wait_to(m + 5 * DIST + 3);
        s    = cyc;
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("pause_state", int'(state), 2);
        chk("pause_busy", int'(busy), 1);
        el = s - (m + 5 * DIST);
        repeat (50) @(negedge clk);
        dir_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step = 1'b1;
            push(cyc + 1, 6 + i);
            @(negedge clk);
            step = 1'b0;
            repeat (3) @(negedge clk);
        end
        chk("step_cnt", int'(step_cnt), 8);
        chk("step_state", int'(state), 2);
        chk("step_up_hold", int'(cnt_up), 0);
        start = 1'b1;
        r = cyc;
        for (int j = 9; j <= 16; j++) push(r + (DIST - el) + DIST * (j - 9), j);
        @(negedge clk);
        start = 1'b0;
        chk("resume_state", int'(state), 1);
        chk("resume_up", int'(cnt_up), 1);
        chk("resume_noclr", int'(cnt_clr), 0);
        wait_to(r + (DIST - el) + 7 * DIST + 1);
        chk("resume_done", int'(state), 3);

        // Continuous wrap
        single = 1'b0;
        start  = 1'b1;
        m = cyc;
        for (int j = 1; j <= 20; j++) push(m + DIST * j, j % 16);
        @(negedge clk);
        start = 1'b0;
        wait_to(m + 16 * DIST);
        chk("wrap_zero", int'(step_cnt), 0);
        chk("wrap_nodone", int'(done), 0);
        wait_to(m + 20 * DIST);
        chk("cont_cnt", int'(step_cnt), 4);
        chk("cont_nodone", int'(done), 0);
        chk("cont_state", int'(state), 1);

        // Simultaneous edges
        wait_to(m + 20 * DIST + 3);
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        chk("ss_run", int'(state), 2);
        repeat (5) @(negedge clk);
        stop = 1'b1;
        step = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        step = 1'b0;
        chk("ss_pause", int'(state), 0);
        chk("ss_busy", int'(busy), 0);
        chk("ss_hold", int'(step_cnt), 4);
        repeat (20) @(negedge clk);

        // Stop coinciding with the wrap
        start = 1'b1;
        m = cyc;
        @(negedge clk);
        start = 1'b0;
        wait_to(m + DIST - 1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("coin_state", int'(state), 2);
        chk("coin_en", int'(cnt_en), 0);
        chk("coin_cnt", int'(step_cnt), 0);
        repeat (10) @(negedge clk);
        start = 1'b1;
        r = cyc;
        push(r + 1, 1);
        push(r + 1 + DIST, 2);
        @(negedge clk);
        start = 1'b0;
        wait_to(r + DIST + 4);

        // Asynchronous reset mid-period
        #2 rst = 1'b1;
        #1;
        chk("arst_state", int'(state), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_cnt", int'(step_cnt), 0);
        chk("arst_up", int'(cnt_up), 0);
        chk("arst_en", int'(cnt_en), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("arst_idle", int'(state), 0);
        chk("sb_empty", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/gray_counter_ctrl.md
# gray_counter_ctrl

Sequencing controller for the Gray counter datapath inside the LED display system. It turns user button levels (start, stop, step, direction, single-sweep) into a paced one-cycle count-enable, a clear pulse, and a direction bit for the Gray counter. Pacing is one enable every `distance` clocks. It also tracks how many steps have been issued and reports run status. It sits between the debounced button inputs and the counter, replacing free-running enable generation.

## Interface
- `N`, default 4: counter width; one full sweep is 2^N steps.
- `distance`, default 10: clocks between consecutive count enables in RUN; legal range ≥ 2.

- `clk` input 1: system clock; all logic on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: level, synchronous and debounced; rising edge starts or resumes.
- `stop` input 1: level; rising edge pauses or aborts.
- `step` input 1: level; rising edge issues a single step while paused.
- `dir_in` input 1: requested direction (1 = up).
- `single` input 1: 1 = stop after 2^N steps; 0 = run continuously.
- `cnt_en` output 1: one-cycle pulse that advances the Gray counter.
- `cnt_clr` output 1: one-cycle pulse that clears the Gray counter.
- `cnt_up` output 1: direction presented to the counter.
- `busy` output 1: high in RUN or PAUSE.
- `done` output 1: high in DONE.
- `state` output 2: IDLE=0, RUN=1, PAUSE=2, DONE=3.
- `step_cnt` output N+1: count of steps issued since the last clear.

## Operation
- **Edge detection.** One previous-value register per button. Edge = input & ~previous. The previous-value registers reset to 1, so a button held through reset never produces an edge.
- **Edge priority** (several edges in the same cycle): stop > start > step. Only the winning edge acts; the others are discarded.
- **IDLE**
  - start edge → RUN.
  - On entry to RUN: `cnt_clr` pulses, `step_cnt` ← 0, prescaler ← 0, `cnt_up` ← `dir_in`.
  - stop and step edges are ignored.
- **RUN**
  - Prescaler counts RUN cycles 1..`distance`, then wraps.
  - `cnt_en` is high for exactly one cycle per prescaler wrap. `step_cnt` increments in that same cycle.
  - stop edge → PAUSE; the prescaler holds its value.
  - step edge is ignored.
- **PAUSE**
  - start edge → RUN. The prescaler resumes from the held value and `cnt_up` is re-latched from `dir_in`. No clear.
  - step edge → one `cnt_en` pulse in the next cycle, `step_cnt` increments, state stays PAUSE, prescaler unchanged.
  - stop edge → IDLE (abort). `step_cnt` is held; no clear.
- **DONE**
  - start edge → RUN with the same clear behaviour as from IDLE.
  - stop edge → IDLE.
  - step edge is ignored.
- **Single-sweep completion.** With `single`=1, the cnt_en pulse that brings `step_cnt` to 2^N also moves the state to DONE (from RUN or PAUSE). `single` is sampled at each step.
- **Continuous mode** (`single`=0): `step_cnt` wraps 2^N−1 → 0. Bit N is never set.
- **Direction.** `cnt_up` changes only when RUN is entered; `dir_in` changes at any other time have no effect.

## Timing
- All outputs are registered. There are no combinational paths from input to output.
- **Reset values:** `state`=IDLE, `cnt_en`=0, `cnt_clr`=0, `cnt_up`=0, `busy`=0, `done`=0, `step_cnt`=0, prescaler=0.
- **Reset mid-operation:** takes effect immediately and asynchronously. Any pulse in flight is lost.
- **Start latency:** start rises before edge k; edge detected at k; after k, `state`=RUN, `busy`=1 and `cnt_clr`=1 for that one cycle.
- **First enable:** the first `cnt_en` is in RUN cycle number `distance`, where the cycle after k is number 1. Subsequent enables come exactly every `distance` cycles. `cnt_en` and `cnt_clr` are never high in the same cycle.
- **Pause:** stop detected at edge k → PAUSE after k. No `cnt_en` pulse in any cycle after k.
  - If the prescaler wrap coincides with edge k, the stop wins and no pulse is issued. The prescaler holds at `distance` and wraps on the first RUN cycle after resume.
- **Step latency:** step detected at edge k while paused → `cnt_en` high in the cycle after k.
- **Done latency:** `done` rises in the same cycle as the final `cnt_en`. `busy` falls in that same cycle.

## Test plan
- **Reset and hold-through-reset:** hold `start` high through `rst`, then release reset → `state` stays 0 and all outputs stay 0. Lower `start`, then raise it → `cnt_clr` pulses once and `state`=1.
- **Single sweep** (N=4, `distance`=10, `single`=1, `dir_in`=1): pulse `start` → exactly 16 `cnt_en` pulses spaced 10 cycles apart, first in RUN cycle 10. Then `done`=1, `state`=3, `step_cnt`=16, `cnt_up`=1.
- **Pause/step/resume:** stop after 5 steps, wait 50 cycles → no pulses. Three step edges → 3 pulses and `step_cnt`=8. Start → next pulse arrives 10 minus the already-elapsed prescaler count later.
- **Continuous wrap** (`single`=0): run 20 steps → `step_cnt` reads 0 after the 16th step and 4 at the end; `done` never asserts.
- **Simultaneous edges:** start and stop rise in the same cycle during RUN → PAUSE. Stop and step rise together during PAUSE → IDLE with no `cnt_en`.
- **Async reset during RUN:** assert `rst` mid-period → outputs return to reset values without waiting for a clock edge; no `cnt_en` follows.
